mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesisable, parametrised memory-write scoreboard for the multicycle MIPS processor. It watches the core's data-memory write port (`memwrite`, `dataadr`, `writedata`) and compares each write against a small programmable table of expected writes. It reports a sticky pass/fail verdict with a cause code and the offending write. The block sits beside `top` in simulation and FPGA builds and replaces hard-coded address/data checks in the per-task benches. It is clocked by the processor clock.

## Interface

Parameters:
- `ADDR_W`, 32, width of `dataadr` and the expected-address entries.
- `DATA_W`, 32, width of `writedata` and the expected-data entries.
- `N_EXP`, 8, depth of the expected-write table (≥1). `IDX_W = $clog2(N_EXP)`, minimum 1.
- `MODE`, 0:
  - 0 = ORDERED: every non-ignored write must match the next table entry, in order.
  - 1 = FINAL: only entry 0 is checked.
- `TIMEOUT`, 1024, maximum consecutive RUN cycles without an accepted match. 0 disables the timeout.

Ports:
- `clk` in 1: processor clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: core write strobe.
- `dataadr` in ADDR_W: write address.
- `writedata` in DATA_W: write data.
- `cfg_we` in 1: table write strobe. Honoured only in IDLE.
- `cfg_idx` in IDX_W: table index. Writes with `cfg_idx ≥ N_EXP` are dropped.
- `cfg_addr` in ADDR_W: expected address.
- `cfg_data` in DATA_W: expected data.
- `cfg_len` in IDX_W+1: number of valid entries. Sampled on `arm`. Values above N_EXP are clamped to N_EXP.
- `ign_lo`, `ign_hi` in ADDR_W each: inclusive ignore range (scratch addresses). The range is empty if `ign_lo > ign_hi`. Both are sampled on `arm`.
- `arm` in 1: start or restart checking.
- `clear` in 1: return to IDLE.
- `done` out 1: verdict reached (PASS or FAIL).
- `pass` out 1: PASS state.
- `fail` out 1: FAIL state.
- `cause` out 2:
  - 0 = none
  - 1 = mismatch
  - 2 = timeout
- `err_idx` out IDX_W: table index being expected at failure.
- `err_addr` out ADDR_W: offending write address, or 0 for a timeout.
- `err_data` out DATA_W: offending write data, or 0 for a timeout.
- `wr_count` out 16: `memwrite` cycles seen in RUN, including ignored ones. Saturates at 0xFFFF.

## Operation

- **States:** IDLE, RUN, PASS, FAIL. All outputs are registered. PASS and FAIL are sticky.
- **Reset:** enter IDLE. Outputs reset to:
  - `done`, `pass`, `fail`, `cause`, `err_*`, `wr_count` = 0.
  - Table, length, ignore bounds, match pointer and timeout counter also cleared to 0.
- **IDLE:**
  - `cfg_we` writes `{cfg_addr, cfg_data}` into table[`cfg_idx`].
  - `arm`:
    - latches length and ignore range, sets pointer = 0, timer = 0, clears `wr_count`, `cause` and `err_*`.
    - goes to RUN.
    - If the clamped length is 0 in ORDERED mode, goes straight to PASS instead.
- **RUN, per cycle with `memwrite` = 1:**
  - Address in the ignore range: count the write only. No compare, timer continues.
  - **ORDERED:**
    - The write is compared with table[ptr].
    - On a match: ptr increments and the timer clears. If ptr was len−1, go to PASS.
    - On a mismatch: go to FAIL with cause 1, `err_idx` = ptr, `err_addr`/`err_data` = the write.
  - **FINAL:**
    - A match with table[0] goes to PASS.
    - Any other non-ignored write goes to FAIL with cause 1 and `err_idx` = 0.
- **RUN, timeout:**
  - With TIMEOUT ≠ 0, the timer increments on every RUN cycle without an accepted match.
  - When the timer reaches TIMEOUT−1 and this cycle has no accepted match: go to FAIL with cause 2, `err_idx` = ptr, `err_addr`/`err_data` = 0.
- **Simultaneous events (priority):** `reset` > `clear` > `arm` > write compare > timeout.
  - A match on the timeout cycle wins: PASS or advance, no FAIL.
  - `arm` in RUN, PASS or FAIL restarts as described for IDLE. Table contents are kept; `cfg_we` is ignored outside IDLE.
  - `clear` returns to IDLE and zeroes the verdict and `err_*` outputs. `wr_count` holds its value.
- **In PASS/FAIL:** further writes are not compared, and `wr_count` is frozen.

## Timing

- **Verdict latency:** a write presented before rising edge k is compared at edge k. `pass`/`fail`/`done` and `err_*` are valid after edge k, i.e. one-cycle latency.
- **Timeout:** with no writes, `fail` is asserted after exactly TIMEOUT rising edges following the `arm` edge.
- **Back-to-back:** writes on consecutive cycles are each checked. There is no stall and no backpressure.
- **Config:** a table entry written at edge k may be armed at edge k+1 and is used from the first RUN cycle.

## Test plan

- **FINAL, scratch write then target:** MODE=1, ign 80..80, table[0]=(84,7).
  - Writes (80,3) then (84,7) → `pass`=1 one cycle after the second write, `wr_count`=2, `cause`=0.
- **FINAL, mismatch:** same configuration, write (60,1) → `fail`=1, `cause`=1, `err_addr`=60, `err_data`=1, `err_idx`=0. A subsequent write (84,7) leaves `fail`=1.
- **ORDERED sequence:** MODE=0, table (0,5),(4,10),(8,15), len 3, ignore range empty.
  - In-order writes → `pass` after the third write.
  - Rerun with the second write (4,11) → `fail`, `cause`=1, `err_idx`=1.
- **Timeout:** TIMEOUT=16, arm, no writes → `fail` with `cause`=2 exactly 16 edges after `arm`.
  - Rerun with a matching write on the 16th cycle → no fail, and the timer restarts.
- **Reset mid-run:** ORDERED, after one accepted match assert `reset` for 1 cycle → all outputs 0, state IDLE.
  - Re-arm after reloading the table; `wr_count` restarts from 0.
- **Edge cases:**
  - `cfg_len`=0 in ORDERED → `pass` the cycle after `arm`.
  - `cfg_len`=N_EXP+3 behaves as N_EXP.
  - `arm` issued during FAIL restarts with `cause`=0.

Source files
------------

// File: rtl/mem_write_checker.sv
// Scoreboard for the core's data-memory write port: compares writes against a programmed table
// and holds a sticky PASS/FAIL verdict with cause code and offending write; outputs lag inputs by one edge.
module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 8,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W  = (N_EXP > 1) ? $clog2(N_EXP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_len,
  input  logic [ADDR_W-1:0] ign_lo,
  input  logic [ADDR_W-1:0] ign_hi,
  input  logic              arm,
  input  logic              clear,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        cause,
  output logic [IDX_W-1:0]  err_idx,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [15:0]       wr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] C_NONE     = 2'd0;
  localparam logic [1:0] C_MISMATCH = 2'd1;
  localparam logic [1:0] C_TIMEOUT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] tbl_addr_q [N_EXP];
  logic [ADDR_W-1:0] tbl_addr_d [N_EXP];
  logic [DATA_W-1:0] tbl_data_q [N_EXP];
  logic [DATA_W-1:0] tbl_data_d [N_EXP];
  logic [IDX_W:0]    len_q, len_d;
  logic [ADDR_W-1:0] ign_lo_q, ign_lo_d, ign_hi_q, ign_hi_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pass_q, pass_d, fail_q, fail_d, done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_data_q, err_data_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [IDX_W:0]    len_clamp;
  logic [IDX_W-1:0]  chk_idx;
  logic              in_ign, is_match, is_last, accepted, decided;

  assign len_clamp = (cfg_len > (IDX_W+1)'(N_EXP)) ? (IDX_W+1)'(N_EXP) : cfg_len;
  // FINAL mode only ever looks at entry 0; ORDERED walks the table.
  assign chk_idx   = (MODE == 1) ? '0 : ptr_q;
  assign in_ign    = (dataadr >= ign_lo_q) && (dataadr <= ign_hi_q);
  assign is_match  = (dataadr == tbl_addr_q[chk_idx]) && (writedata == tbl_data_q[chk_idx]);
  assign is_last   = ({1'b0, ptr_q} + (IDX_W+1)'(1)) == len_q;

  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    tbl_data_d = tbl_data_q;
    len_d      = len_q;
    ign_lo_d   = ign_lo_q;
    ign_hi_d   = ign_hi_q;
    ptr_d      = ptr_q;
    tmr_d      = tmr_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    cause_d    = cause_q;
    err_idx_d  = err_idx_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    wr_count_d = wr_count_q;
    accepted   = 1'b0;
    decided    = 1'b0;

    if (clear) begin
      state_d    = S_IDLE;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      cause_d    = C_NONE;
      err_idx_d  = '0;
      err_addr_d = '0;
      err_data_d = '0;
    end else if (arm) begin
      len_d      = len_clamp;
      ign_lo_d   = ign_lo;
      ign_hi_d   = ign_hi;
      ptr_d      = '0;
      tmr_d      = '0;
      wr_count_d = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      cause_d    = C_NONE;
      err_idx_d  = '0;
      err_addr_d = '0;
      err_data_d = '0;
      if (MODE == 0 && len_clamp == '0) begin
        state_d = S_PASS;
        pass_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we && int'(cfg_idx) < N_EXP) begin
            tbl_addr_d[cfg_idx] = cfg_addr;
            tbl_data_d[cfg_idx] = cfg_data;
          end
        end
        S_RUN: begin
          if (memwrite) begin
            if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            if (!in_ign) begin
              if (is_match) begin
                accepted = 1'b1;
                tmr_d    = '0;
                if (MODE == 1 || is_last) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
                end else begin
                  ptr_d = ptr_q + IDX_W'(1);
                end
              end else begin
                decided    = 1'b1;
                state_d    = S_FAIL;
                fail_d     = 1'b1;
                cause_d    = C_MISMATCH;
                err_idx_d  = chk_idx;
                err_addr_d = dataadr;
                err_data_d = writedata;
              end
            end
          end
          // A compare verdict or an accepted match pre-empts the timeout.
          if (TIMEOUT != 0 && !accepted && !decided) begin
            if (tmr_q == TMR_LAST) begin
              state_d    = S_FAIL;
              fail_d     = 1'b1;
              cause_d    = C_TIMEOUT;
              err_idx_d  = ptr_q;
              err_addr_d = '0;
              err_data_d = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    done_d = pass_d | fail_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N_EXP; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
      len_q      <= '0;
      ign_lo_q   <= '0;
      ign_hi_q   <= '0;
      ptr_q      <= '0;
      tmr_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      cause_q    <= C_NONE;
      err_idx_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_data_q <= tbl_data_d;
      len_q      <= len_d;
      ign_lo_q   <= ign_lo_d;
      ign_hi_q   <= ign_hi_d;
      ptr_q      <= ptr_d;
      tmr_q      <= tmr_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
      err_idx_q  <= err_idx_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign cause    = cause_q;
  assign err_idx  = err_idx_q;
  assign err_addr = err_addr_q;
  assign err_data = err_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: one ORDERED and one FINAL checker share stimulus; each check targets one of them.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset, memwrite, cfg_we, arm, clear;
  logic [31:0] dataadr, writedata, cfg_addr, cfg_data, ign_lo, ign_hi;
  logic [2:0]  cfg_idx;
  logic [3:0]  cfg_len;

  logic        o_done, o_pass, o_fail, f_done, f_pass, f_fail;
  logic [1:0]  o_cause, f_cause;
  logic [2:0]  o_err_idx, f_err_idx;
  logic [31:0] o_err_addr, o_err_data, f_err_addr, f_err_data;
  logic [15:0] o_wr_count, f_wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .N_EXP(8), .MODE(0), .TIMEOUT(16)) dut_ord (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .ign_lo(ign_lo), .ign_hi(ign_hi), .arm(arm), .clear(clear),
    .done(o_done), .pass(o_pass), .fail(o_fail), .cause(o_cause), .err_idx(o_err_idx),
    .err_addr(o_err_addr), .err_data(o_err_data), .wr_count(o_wr_count));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .N_EXP(8), .MODE(1), .TIMEOUT(16)) dut_fin (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .ign_lo(ign_lo), .ign_hi(ign_hi), .arm(arm), .clear(clear),
    .done(f_done), .pass(f_pass), .fail(f_fail), .cause(f_cause), .err_idx(f_err_idx),
    .err_addr(f_err_addr), .err_data(f_err_data), .wr_count(f_wr_count));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] len, input logic [31:0] lo, input logic [31:0] hi);
    arm = 1'b1; cfg_len = len; ign_lo = lo; ign_hi = hi;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic load_seq();
    cfg(3'd0, 32'd0, 32'd5);
    cfg(3'd1, 32'd4, 32'd10);
    cfg(3'd2, 32'd8, 32'd15);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; cfg_we = 1'b0; arm = 1'b0; clear = 1'b0;
    dataadr = '0; writedata = '0; cfg_addr = '0; cfg_data = '0; cfg_idx = '0;
    cfg_len = '0; ign_lo = '0; ign_hi = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_pass", {63'd0, o_pass}, 64'd0);
    check("rst_fail", {63'd0, o_fail}, 64'd0);
    check("rst_cause", {62'd0, o_cause}, 64'd0);
    check("rst_wrcnt", {48'd0, o_wr_count}, 64'd0);

    // FINAL: scratch write ignored, then target write passes
    cfg(3'd0, 32'd84, 32'd7);
    do_arm(4'd1, 32'd80, 32'd80);
    wr(32'd80, 32'd3);
    check("fin_scratch_pass", {63'd0, f_pass}, 64'd0);
    wr(32'd84, 32'd7);
    check("fin_pass", {63'd0, f_pass}, 64'd1);
    check("fin_done", {63'd0, f_done}, 64'd1);
    check("fin_wrcnt", {48'd0, f_wr_count}, 64'd2);
    check("fin_cause0", {62'd0, f_cause}, 64'd0);

    // FINAL mismatch, then verdict stays sticky
    do_arm(4'd1, 32'd80, 32'd80);
    wr(32'd60, 32'd1);
    check("fin_mm_fail", {63'd0, f_fail}, 64'd1);
    check("fin_mm_cause", {62'd0, f_cause}, 64'd1);
    check("fin_mm_addr", {32'd0, f_err_addr}, 64'd60);
    check("fin_mm_data", {32'd0, f_err_data}, 64'd1);
    check("fin_mm_idx", {61'd0, f_err_idx}, 64'd0);
    wr(32'd84, 32'd7);
    check("fin_sticky_fail", {63'd0, f_fail}, 64'd1);
    check("fin_sticky_pass", {63'd0, f_pass}, 64'd0);
    check("fin_frozen_cnt", {48'd0, f_wr_count}, 64'd1);

    do_clear();
    check("clr_done", {63'd0, f_done}, 64'd0);
    check("clr_cause", {62'd0, f_cause}, 64'd0);
    check("clr_erraddr", {32'd0, f_err_addr}, 64'd0);
    check("clr_wrcnt_hold", {48'd0, f_wr_count}, 64'd1);

    // ORDERED sequence with empty ignore range
    load_seq();
    do_arm(4'd3, 32'd1, 32'd0);
    wr(32'd0, 32'd5);
    check("ord_w1_pass", {63'd0, o_pass}, 64'd0);
    wr(32'd4, 32'd10);
    check("ord_w2_pass", {63'd0, o_pass}, 64'd0);
    wr(32'd8, 32'd15);
    check("ord_pass", {63'd0, o_pass}, 64'd1);
    check("ord_wrcnt", {48'd0, o_wr_count}, 64'd3);

    do_arm(4'd3, 32'd1, 32'd0);
    check("ord_rearm_pass", {63'd0, o_pass}, 64'd0);
    wr(32'd0, 32'd5);
    wr(32'd4, 32'd11);
    check("ord_mm_fail", {63'd0, o_fail}, 64'd1);
    check("ord_mm_cause", {62'd0, o_cause}, 64'd1);
    check("ord_mm_idx", {61'd0, o_err_idx}, 64'd1);
    check("ord_mm_addr", {32'd0, o_err_addr}, 64'd4);
    check("ord_mm_data", {32'd0, o_err_data}, 64'd11);

    // arm during FAIL restarts cleanly; this arm also starts the timeout run
    do_arm(4'd3, 32'd1, 32'd0);
    check("arm_in_fail_cause", {62'd0, o_cause}, 64'd0);
    check("arm_in_fail_fail", {63'd0, o_fail}, 64'd0);
    check("arm_in_fail_addr", {32'd0, o_err_addr}, 64'd0);
    repeat (15) @(negedge clk);
    check("to_15_fail", {63'd0, o_fail}, 64'd0);
    @(negedge clk);
    check("to_16_fail", {63'd0, o_fail}, 64'd1);
    check("to_cause", {62'd0, o_cause}, 64'd2);
    check("to_idx", {61'd0, o_err_idx}, 64'd0);
    check("to_addr", {32'd0, o_err_addr}, 64'd0);

    // match on the 16th cycle rescues and restarts the timer
    do_arm(4'd3, 32'd1, 32'd0);
    repeat (15) @(negedge clk);
    wr(32'd0, 32'd5);
    check("to_rescue_fail", {63'd0, o_fail}, 64'd0);
    repeat (15) @(negedge clk);
    check("to2_15_fail", {63'd0, o_fail}, 64'd0);
    @(negedge clk);
    check("to2_16_fail", {63'd0, o_fail}, 64'd1);
    check("to2_cause", {62'd0, o_cause}, 64'd2);
    check("to2_idx", {61'd0, o_err_idx}, 64'd1);

    // reset mid-run clears everything, including the table
    do_arm(4'd3, 32'd1, 32'd0);
    wr(32'd0, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_done", {63'd0, o_done}, 64'd0);
    check("mrst_wrcnt", {48'd0, o_wr_count}, 64'd0);
    check("mrst_cause", {62'd0, o_cause}, 64'd0);
    do_arm(4'd3, 32'd1, 32'd0);
    wr(32'd0, 32'd5);
    check("mrst_tbl_zero_fail", {63'd0, o_fail}, 64'd1);
    check("mrst_tbl_zero_data", {32'd0, o_err_data}, 64'd5);
    do_clear();
    load_seq();
    do_arm(4'd3, 32'd1, 32'd0);
    check("mrst_rearm_cnt", {48'd0, o_wr_count}, 64'd0);
    wr(32'd0, 32'd5);
    wr(32'd4, 32'd10);
    wr(32'd8, 32'd15);
    check("mrst_rerun_pass", {63'd0, o_pass}, 64'd1);
    check("mrst_rerun_cnt", {48'd0, o_wr_count}, 64'd3);

    // zero length passes immediately in ORDERED only
    do_arm(4'd0, 32'd1, 32'd0);
    check("len0_pass", {63'd0, o_pass}, 64'd1);
    check("len0_done", {63'd0, o_done}, 64'd1);
    check("len0_fin_done", {63'd0, f_done}, 64'd0);

    // over-long length clamps to the table depth
    do_clear();
    for (int i = 0; i < 8; i++) cfg(3'(i), 32'(16 * i), 32'(100 + i));
    do_arm(4'd11, 32'd1, 32'd0);
    for (int i = 0; i < 7; i++) wr(32'(16 * i), 32'(100 + i));
    check("clamp_7_pass", {63'd0, o_pass}, 64'd0);
    wr(32'd112, 32'd107);
    check("clamp_8_pass", {63'd0, o_pass}, 64'd1);
    check("clamp_cnt", {48'd0, o_wr_count}, 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
